// File: rtl/iref_ctrl_pkg.sv
// Shared types and helpers for the IREF power-sequencing controller.
// The state enum encodes the five sequencing phases; calc_cnt_w sizes the delay counter.
package iref_ctrl_pkg;

    typedef enum logic [2:0] {
        IREF_OFF      = 3'd0,
        IREF_CHARGE   = 3'd1,
        IREF_SETTLE   = 3'd2,
        IREF_ON       = 3'd3,
        IREF_SHUTDOWN = 3'd4
    } iref_state_e;

    function automatic int calc_cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/iref_ctrl_if.sv
// Enable request from the PMU register bank and status/pin drive toward the IREF block.
// master = requester (PMU side), slave = iref_ctrl.
interface iref_ctrl_if;
    logic en;
    logic iref_pd;
    logic iref_charge;
    logic ready;
    logic busy;
    logic ready_pulse;

    modport master (
        output en,
        input  iref_pd, iref_charge, ready, busy, ready_pulse
    );

    modport slave (
        input  en,
        output iref_pd, iref_charge, ready, busy, ready_pulse
    );
endinterface

// File: rtl/iref_delay_cnt.sv
// Loadable down-counter with zero flag; load has priority, decrement saturates at zero.
// Registered count, zero flag decoded combinationally from the register.
module iref_delay_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/iref_ctrl.sv
// Sequences IREF pd/charge from a single enable level: release pd, charge, settle, report ready.
// Outputs are registered from the next state so they switch on the same edge as the FSM.
module iref_ctrl
    import iref_ctrl_pkg::*;
#(
    parameter int CHARGE_CYCLES = 1000,
    parameter int SETTLE_CYCLES = 200,
    parameter int OFF_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        rst,
    iref_ctrl_if.slave  bus
);

    localparam int CNT_W = calc_cnt_w(CHARGE_CYCLES, SETTLE_CYCLES, OFF_CYCLES);
    localparam logic [CNT_W-1:0] CHG_LD = CNT_W'(CHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(OFF_CYCLES - 1);

    iref_state_e      state_q, state_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    logic pd_q, pd_d;
    logic charge_q, charge_d;
    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic pulse_q, pulse_d;

    iref_delay_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IREF_OFF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            IREF_OFF: begin
                if (bus.en) begin
                    state_d      = IREF_CHARGE;
                    cnt_load     = 1'b1;
                    cnt_load_val = CHG_LD;
                end
            end
            IREF_CHARGE: begin
                // Abort straight to OFF: charge is already high, so pd may re-assert at once.
                if (!bus.en) begin
                    state_d = IREF_OFF;
                end else if (cnt_zero) begin
                    state_d      = IREF_SETTLE;
                    cnt_load     = 1'b1;
                    cnt_load_val = SET_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            IREF_SETTLE: begin
                if (!bus.en) begin
                    state_d      = IREF_SHUTDOWN;
                    cnt_load     = 1'b1;
                    cnt_load_val = OFF_LD;
                end else if (cnt_zero) begin
                    state_d = IREF_ON;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            IREF_ON: begin
                if (!bus.en) begin
                    state_d      = IREF_SHUTDOWN;
                    cnt_load     = 1'b1;
                    cnt_load_val = OFF_LD;
                end
            end
            IREF_SHUTDOWN: begin
                if (cnt_zero) state_d = IREF_OFF;
                else          cnt_dec = 1'b1;
            end
            default: state_d = IREF_OFF;
        endcase
    end

    always_comb begin
        pd_d     = 1'b0;
        charge_d = 1'b0;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        pulse_d  = 1'b0;
        case (state_d)
            IREF_OFF:      begin pd_d = 1'b1; charge_d = 1'b1; end
            IREF_CHARGE:   begin charge_d = 1'b1; busy_d = 1'b1; end
            IREF_SETTLE:   busy_d = 1'b1;
            IREF_ON:       begin ready_d = 1'b1; pulse_d = (state_q != IREF_ON); end
            IREF_SHUTDOWN: begin charge_d = 1'b1; busy_d = 1'b1; end
            default:       begin pd_d = 1'b1; charge_d = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pd_q     <= 1'b1;
            charge_q <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            pd_q     <= pd_d;
            charge_q <= charge_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            pulse_q  <= pulse_d;
        end
    end

    assign bus.iref_pd     = pd_q;
    assign bus.iref_charge = charge_q;
    assign bus.ready       = ready_q;
    assign bus.busy        = busy_q;
    assign bus.ready_pulse = pulse_q;

endmodule

// File: doc/iref_ctrl.md
Name: iref_ctrl

Overview:
Power-sequencing controller that drives the RF current-reference generator's `pd` (power-down) and `charge` pins, the inputs the IREF model monitors.
- Turns a single software/PMU enable level into the required sequence: release pd, hold charge for a programmed interval, release charge, settle, then report ready.
- Sits between the RF power-management register bank and the IREF analog block.

Parameters:
- CHARGE_CYCLES, 1000: cycles charge stays high after pd is released (must be >= 1).
- SETTLE_CYCLES, 200: cycles after charge release before ready asserts (>= 1).
- OFF_CYCLES, 16: cycles charge is re-asserted before pd re-asserts on shutdown (>= 1).
- CNT_W, $clog2(max(CHARGE_CYCLES,SETTLE_CYCLES,OFF_CYCLES)+1): internal counter width (derived, not overridden).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  request level: 1 = IREF on, 0 = IREF off. Synchronous to clk.
- iref_pd  output  1  to IREF pd pin; 1 = powered down.
- iref_charge  output  1  to IREF charge pin; 1 = charging.
- ready  output  1  IREF powered and settled.
- busy  output  1  sequence in progress (CHARGE, SETTLE or SHUTDOWN).
- ready_pulse  output  1  single-cycle pulse on ready rising.

Behaviour:
- Reset values: state=OFF, iref_pd=1, iref_charge=1, ready=0, busy=0, ready_pulse=0, counter=0.
- Async reset forces these values immediately, mid-sequence included.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- States and transitions:
  - OFF: pd=1, charge=1, ready=0, busy=0.
    - en=1 -> CHARGE, counter <- CHARGE_CYCLES-1.
  - CHARGE: pd=0, charge=1, busy=1.
    - en=0 -> OFF directly (abort; charge already high).
    - Else counter==0 -> SETTLE, counter <- SETTLE_CYCLES-1.
    - Else counter decrements.
  - SETTLE: pd=0, charge=0, busy=1.
    - en=0 -> SHUTDOWN, counter <- OFF_CYCLES-1.
    - Else counter==0 -> ON.
    - Else decrement.
  - ON: pd=0, charge=0, ready=1, busy=0.
    - en=0 -> SHUTDOWN, counter <- OFF_CYCLES-1.
  - SHUTDOWN: pd=0, charge=1, ready=0, busy=1.
    - counter==0 -> OFF, else decrement.
    - en is ignored; the sequence always completes.
    - If en is still 1 on return to OFF, the next edge re-enters CHARGE.
- Timing from en=1 sampled at edge E:
  - pd falls at E.
  - charge falls at E+CHARGE_CYCLES.
  - ready and ready_pulse rise at E+CHARGE_CYCLES+SETTLE_CYCLES.
- Timing from en=0 sampled at edge F (state ON):
  - ready=0 and charge=1 at F.
  - pd=1 at F+OFF_CYCLES.
- Invariants:
  - pd=1 implies charge=1.
  - ready=1 implies pd=0 and charge=0.
  - ready and busy are never both 1.
- ready_pulse is high exactly one cycle: the cycle whose leading edge enters ON.
- en glitches shorter than one cycle are not filtered; en must be synchronous.
- Counter never wraps; it is reloaded on every state entry that uses it.

Decomposition:
- Package iref_ctrl_pkg:
  - state enum (IREF_OFF, IREF_CHARGE, IREF_SETTLE, IREF_ON, IREF_SHUTDOWN), 3-bit encoding.
  - Helper function computing CNT_W from the three cycle parameters.
- One sub-module, iref_delay_cnt:
  - Loadable down-counter with load, load value, and zero flag.
  - Parameterized by CNT_W.
  - Reset to 0.

Test Plan (CHARGE_CYCLES=4, SETTLE_CYCLES=3, OFF_CYCLES=2):
1. Reset, then hold en=0 for 10 cycles -> pd=1, charge=1, ready=0, busy=0 throughout.
2. en=1 sampled at edge 5 -> pd=0 at edge 5; charge=0 at edge 9; ready=1 and one-cycle ready_pulse at edge 12; busy=1 for edges 5..11.
3. From ON, en=0 sampled at edge 20 -> ready=0, charge=1 at edge 20; pd=1 at edge 22; busy=0 at edge 22.
4. en=1 at edge 5, en=0 at edge 7 (in CHARGE) -> pd=1 at edge 7, charge stays 1, ready never asserts.
5. From ON, pulse en=0 for one cycle at edge 20, en=1 again at edge 21 -> shutdown completes (pd=1 at edge 22); CHARGE re-entered at edge 23 (pd=0); ready at edge 30.
6. Assert rst asynchronously mid-SETTLE -> pd=1, charge=1, ready=0, busy=0 immediately without a clock edge. After rst release with en=1, the full sequence restarts from CHARGE.
